// File: rtl/h01b_key_matrix_if.sv
// Scan-event and map-write bus between the PS/2 decoder side and h01b_key_matrix.
`timescale 1ns/1ps
interface h01b_key_matrix_if #(
    parameter int ROWS = 11,
    parameter int COLS = 5
);
    localparam int EW = 2 + $clog2(ROWS) + $clog2(COLS);

    logic          EV_VALID;
    logic [7:0]    EV_SCAN;
    logic          EV_PRESSED;
    logic          EV_EXTENDED;
    logic          MAP_WE;
    logic [8:0]    MAP_ADDR;
    logic [EW-1:0] MAP_WDATA;
    logic          READY;

    modport master (
        output EV_VALID, EV_SCAN, EV_PRESSED, EV_EXTENDED,
        output MAP_WE, MAP_ADDR, MAP_WDATA,
        input  READY
    );

    modport slave (
        input  EV_VALID, EV_SCAN, EV_PRESSED, EV_EXTENDED,
        input  MAP_WE, MAP_ADDR, MAP_WDATA,
        output READY
    );
endinterface

// File: rtl/h01b_key_matrix.sv
// PS/2 scan events -> run-time mapped, scanned key matrix with clear-all.
// Optional Ctrl+F12 chord reset pulse is built only when KBM_CHORD_RESET_EN is defined.
`timescale 1ns/1ps
module h01b_key_matrix #(
    parameter int ROWS     = 11,
    parameter int COLS     = 5,
    parameter int HOLD_CYC = 1000,
    parameter int RST_CYC  = 4096
) (
    input  logic             KB_CLK,
    input  logic             RESET_N,
    h01b_key_matrix_if.slave bus,
    input  logic             CLR_ALL,
    input  logic [ROWS-1:0]  KEY_ADDR,
    output logic [COLS-1:0]  KEY_DATA,
    output logic             KEY_PRESSED,
    output logic             RESET_KEY_N
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int EW = 2 + RW + CW;
    localparam int NK = ROWS * COLS;
    localparam int IW = $clog2(NK);
    localparam logic [EW-1:0] ROW_MSK = EW'((1 << RW) - 1);
    localparam logic [EW-1:0] COL_MSK = EW'((1 << CW) - 1);

    if (ROWS < 2 || ROWS > 16 || COLS < 1 || COLS > 8 || HOLD_CYC < 1 || RST_CYC < 1)
    begin : g_param_check
        $error("h01b_key_matrix: parameter out of range");
    end

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t        state;
    logic [8:0]    init_cnt;
    logic          ready_q;
    logic [EW-1:0] map_mem [512];
    logic          map_we;
    logic [8:0]    map_wa;
    logic [EW-1:0] map_wd;
    logic          vld_p0;
    logic          pressed_p0;
    logic [EW-1:0] ent_p0;
    logic [1:0]    ent_kind;
    logic [EW-1:0] ent_row;
    logic [EW-1:0] ent_col;
    logic          key_hit;
    logic [IW-1:0] key_idx;
    logic [NK-1:0] matrix;

    // INIT sweeps every map address to "unmapped" before events are accepted
    always_ff @(posedge KB_CLK) begin
        if (!RESET_N) begin
            state    <= S_INIT;
            init_cnt <= '0;
            ready_q  <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    init_cnt <= init_cnt + 9'd1;
                    if (init_cnt == 9'h1FF) begin
                        state   <= S_RUN;
                        ready_q <= 1'b1;
                    end
                end
                default: ready_q <= 1'b1;
            endcase
        end
    end

    assign bus.READY = ready_q;

    always_comb begin
        map_we = bus.MAP_WE;
        map_wa = bus.MAP_ADDR;
        map_wd = bus.MAP_WDATA;
        if (state == S_INIT) begin
            map_we = 1'b1;
            map_wa = init_cnt;
            map_wd = '0;
        end
    end

    // Stage 0: map lookup; a same-cycle write to the read address returns old data
    always_ff @(posedge KB_CLK) begin
        if (map_we) map_mem[map_wa] <= map_wd;
        ent_p0     <= map_mem[{bus.EV_EXTENDED, bus.EV_SCAN}];
        pressed_p0 <= bus.EV_PRESSED;
    end

    always_ff @(posedge KB_CLK) begin
        if (!RESET_N) vld_p0 <= 1'b0;
        else          vld_p0 <= bus.EV_VALID && (state == S_RUN);
    end

    // Stage 1: decode the entry and apply it to the matrix
    always_comb begin
        ent_kind = ent_p0[EW-1:EW-2];
        ent_row  = (ent_p0 >> CW) & ROW_MSK;
        ent_col  = ent_p0 & COL_MSK;
        key_hit  = vld_p0 && (ent_kind == 2'b01) &&
                   (ent_row < EW'(ROWS)) && (ent_col < EW'(COLS));
        key_idx  = IW'(int'(ent_row) * COLS + int'(ent_col));
    end

    always_ff @(posedge KB_CLK) begin
        if (!RESET_N)     matrix <= '1;
        else if (CLR_ALL) matrix <= '1;
        else if (key_hit) matrix[key_idx] <= ~pressed_p0;
    end

    // Selected rows are wired-AND onto the column lines
    always_comb begin
        KEY_DATA = '1;
        for (int r = 0; r < ROWS; r++)
            if (!KEY_ADDR[r]) KEY_DATA = KEY_DATA & matrix[r*COLS +: COLS];
    end

    assign KEY_PRESSED = ~&matrix;

`ifdef KBM_CHORD_RESET_EN
    localparam int HW = $clog2(HOLD_CYC + 1);
    localparam int PW = $clog2(RST_CYC + 1);

    logic          chord_a;
    logic          chord_b;
    logic          armed;
    logic          rkn_q;
    logic [HW-1:0] hold_cnt;
    logic [PW-1:0] pulse_cnt;

    // armed drops on firing and returns only once either chord key is released
    always_ff @(posedge KB_CLK) begin
        if (!RESET_N) begin
            chord_a   <= 1'b0;
            chord_b   <= 1'b0;
            armed     <= 1'b1;
            rkn_q     <= 1'b1;
            hold_cnt  <= '0;
            pulse_cnt <= '0;
        end else begin
            if (vld_p0 && ent_kind == 2'b10) chord_a <= pressed_p0;
            if (vld_p0 && ent_kind == 2'b11) chord_b <= pressed_p0;
            if (!(chord_a && chord_b)) begin
                hold_cnt <= '0;
                armed    <= 1'b1;
            end else if (armed) begin
                if (hold_cnt == HW'(HOLD_CYC - 1)) begin
                    if (rkn_q) begin
                        armed     <= 1'b0;
                        hold_cnt  <= '0;
                        rkn_q     <= 1'b0;
                        pulse_cnt <= PW'(RST_CYC - 1);
                    end
                end else begin
                    hold_cnt <= hold_cnt + HW'(1);
                end
            end
            if (!rkn_q) begin
                if (pulse_cnt != '0) pulse_cnt <= pulse_cnt - PW'(1);
                else                 rkn_q     <= 1'b1;
            end
        end
    end

    assign RESET_KEY_N = rkn_q;
`else
    assign RESET_KEY_N = 1'b1;
`endif
endmodule
